seq_bcd_frame_sampler: RTL and testbench

//  Frame-synchronous, iterative (double-dabble) signed-binary to BCD converter feeding the on-screen sequence renderer.

---
 rtl/seq_disp_pkg.sv | 36 +++
 rtl/dabble_step.sv | 30 +++
 rtl/seq_bcd_frame_sampler.sv | 125 ++++++++++++
 tb/tb_seq_bcd_frame_sampler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_disp_pkg.sv
// rtl/seq_disp_pkg.sv - shared constants, state encoding and helpers for the BCD frame sampler
// Purpose: common definitions imported by seq_bcd_frame_sampler and dabble_step.
// Contents: BCD digit width, FSM state enum, BCD nine constant,
//           pow10() for the saturation limit, clog2() for counter sizing.
package seq_disp_pkg;

  localparam int BCD_WIDTH = 4;
  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dabble_step.sv
// rtl/dabble_step.sv - one combinational double-dabble iteration
// Purpose: applies +3 to every BCD digit >= 5, then shifts the whole
//          {digits, binary} vector left by one bit.
// Ports:
//   din   in   DIGITS*4+SEQ_LEN   current shift register contents
//   dout  out  DIGITS*4+SEQ_LEN   contents after one iteration
module dabble_step
  import seq_disp_pkg::*;
#(
  parameter int SEQ_LEN = 20,
  parameter int DIGITS  = 6
) (
  input  logic [DIGITS*BCD_WIDTH+SEQ_LEN-1:0] din,
  output logic [DIGITS*BCD_WIDTH+SEQ_LEN-1:0] dout
);

  logic [DIGITS*BCD_WIDTH+SEQ_LEN-1:0] adj;

  always_comb begin
    adj = din;
    // Digits sit above the binary field, digit 0 in the lowest nibble.
    for (int i = 0; i < DIGITS; i++) begin
      if (din[SEQ_LEN+i*BCD_WIDTH +: BCD_WIDTH] >= 4'd5) begin
        adj[SEQ_LEN+i*BCD_WIDTH +: BCD_WIDTH] = din[SEQ_LEN+i*BCD_WIDTH +: BCD_WIDTH] + 4'd3;
      end
    end
    dout = adj << 1;
  end

endmodule

// File: rtl/seq_bcd_frame_sampler.sv
// rtl/seq_bcd_frame_sampler.sv - frame-synchronous serial signed-binary to BCD converter
// Purpose: samples a two's-complement value on frame_start, converts its
//          magnitude one bit per clock and publishes sign + digits atomically.
// Ports:
//   clk          in   1                  rising-edge clock
//   rst_n        in   1                  synchronous active-low reset
//   frame_start  in   1                  sample request pulse
//   seq          in   SEQ_LEN            signed value to display
//   ovr_clr      in   1                  clears sticky overrun
//   busy         out  1                  conversion in progress
//   bcd_valid    out  1                  one-cycle pulse when outputs update
//   bcd_seq      out  DIGITS*4           magnitude digits, units in LSBs
//   seq_neg      out  1                  displayed value negative
//   sat          out  1                  magnitude exceeded display range
//   overrun      out  1                  sticky: frame_start while busy
module seq_bcd_frame_sampler
  import seq_disp_pkg::*;
#(
  parameter int SEQ_LEN = 20,
  parameter int DIGITS  = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic [SEQ_LEN-1:0]            seq,
  input  logic                          ovr_clr,
  output logic                          busy,
  output logic                          bcd_valid,
  output logic [DIGITS*BCD_WIDTH-1:0]   bcd_seq,
  output logic                          seq_neg,
  output logic                          sat,
  output logic                          overrun
);

  localparam int BW = DIGITS * BCD_WIDTH;
  localparam int SW = BW + SEQ_LEN;
  localparam int CW = clog2(SEQ_LEN + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sreg;
  logic [SW-1:0]   sreg_step;
  logic            neg_q;
  logic            sat_q;
  logic [SEQ_LEN-1:0] mag_c;
  logic            sat_c;

  // Negating the most negative value yields 2^(SEQ_LEN-1) when read as unsigned.
  assign mag_c = seq[SEQ_LEN-1] ? ((~seq) + {{(SEQ_LEN-1){1'b0}}, 1'b1}) : seq;
  assign sat_c = {{(64-SEQ_LEN){1'b0}}, mag_c} > LIMIT;
  assign busy  = (state != ST_IDLE);

  dabble_step #(
    .SEQ_LEN (SEQ_LEN),
    .DIGITS  (DIGITS)
  ) u_step (
    .din  (sreg),
    .dout (sreg_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == CW'(1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      sreg      <= '0;
      neg_q     <= 1'b0;
      sat_q     <= 1'b0;
      bcd_seq   <= '0;
      seq_neg   <= 1'b0;
      sat       <= 1'b0;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;

      // A set in the same cycle as a clear must win.
      if (frame_start && state != ST_IDLE) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            neg_q <= seq[SEQ_LEN-1];
            sat_q <= sat_c;
            sreg  <= {{BW{1'b0}}, mag_c};
            cnt   <= CW'(SEQ_LEN);
          end
        end
        ST_SHIFT: begin
          sreg <= sreg_step;
          cnt  <= cnt - CW'(1);
        end
        ST_DONE: begin
          bcd_seq   <= sat_q ? {DIGITS{BCD_NINE}} : sreg[SW-1 -: BW];
          seq_neg   <= neg_q;
          sat       <= sat_q;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bcd_frame_sampler.sv
// tb/tb_seq_bcd_frame_sampler.sv - self-checking bench for seq_bcd_frame_sampler
module tb_seq_bcd_frame_sampler;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [19:0] seq;
  logic        ovr_clr;

  logic        busy6, bcd_valid6, seq_neg6, sat6, overrun6;
  logic [23:0] bcd6;
  logic        busy4, bcd_valid4, seq_neg4, sat4, overrun4;
  logic [15:0] bcd4;

  int n_vec;
  int n_err;

  seq_bcd_frame_sampler #(.SEQ_LEN(20), .DIGITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .seq(seq), .ovr_clr(ovr_clr),
    .busy(busy6), .bcd_valid(bcd_valid6), .bcd_seq(bcd6), .seq_neg(seq_neg6),
    .sat(sat6), .overrun(overrun6)
  );

  seq_bcd_frame_sampler #(.SEQ_LEN(20), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .seq(seq), .ovr_clr(ovr_clr),
    .busy(busy4), .bcd_valid(bcd_valid4), .bcd_seq(bcd4), .seq_neg(seq_neg4),
    .sat(sat4), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] seq;
    logic [23:0] bcd6;
    logic        sat6;
    logic [15:0] bcd4;
    logic        sat4;
    logic        neg;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns the number of clocks until bcd_valid6, or 0 if it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bcd_valid6) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [23:0] prev;

    n_vec = 0;
    n_err = 0;

    vt[0] = '{20'd12345,  24'h012345, 1'b0, 16'h9999, 1'b1, 1'b0};
    vt[1] = '{20'hFFFFF,  24'h000001, 1'b0, 16'h0001, 1'b0, 1'b1};
    vt[2] = '{20'd0,      24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[3] = '{20'h80000,  24'h524288, 1'b0, 16'h9999, 1'b1, 1'b1};
    vt[4] = '{20'd42,     24'h000042, 1'b0, 16'h0042, 1'b0, 1'b0};
    vt[5] = '{20'h7FFFF,  24'h524287, 1'b0, 16'h9999, 1'b1, 1'b0};
    vt[6] = '{20'hFCFC7,  24'h012345, 1'b0, 16'h9999, 1'b1, 1'b1};
    vt[7] = '{20'd9999,   24'h009999, 1'b0, 16'h9999, 1'b0, 1'b0};
    vt[8] = '{20'd10000,  24'h010000, 1'b0, 16'h9999, 1'b1, 1'b0};

    rst_n = 1'b0;
    frame_start = 1'b0;
    seq = 20'd0;
    ovr_clr = 1'b0;
    tick();
    tick();
    chk("rst_bcd", bcd6, 24'h0);
    chk("rst_neg", seq_neg6, 1'b0);
    chk("rst_sat", sat6, 1'b0);
    chk("rst_valid", bcd_valid6, 1'b0);
    chk("rst_busy", busy6, 1'b0);
    chk("rst_ovr", overrun6, 1'b0);
    rst_n = 1'b1;
    tick();

    // Back-to-back frames: each new frame_start lands on the cycle after DONE.
    prev = 24'h0;
    for (int v = 0; v < NV; v++) begin
      seq = vt[v].seq;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("busy_e0", busy6, 1'b1);
      chk("valid_e0", bcd_valid6, 1'b0);
      seq = ~vt[v].seq;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (c == 10) chk("hold_mid", bcd6, prev);
        if (bcd_valid6) begin
          lat = c;
          break;
        end
      end
      chk("latency", lat, 21);
      chk("bcd6", bcd6, vt[v].bcd6);
      chk("neg6", seq_neg6, vt[v].neg);
      chk("sat6", sat6, vt[v].sat6);
      chk("valid4", bcd_valid4, 1'b1);
      chk("bcd4", bcd4, vt[v].bcd4);
      chk("sat4", sat4, vt[v].sat4);
      chk("neg4", seq_neg4, vt[v].neg);
      chk("busy_done", busy6, 1'b0);
      chk("no_ovr", overrun6, 1'b0);
      prev = vt[v].bcd6;
    end

    // Second frame_start mid-conversion is ignored but flagged.
    seq = 20'd12345;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    seq = 20'd7;
    for (int i = 0; i < 4; i++) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_set", overrun6, 1'b1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bcd_valid6) begin
        pulses++;
        chk("ovr_bcd", bcd6, 24'h012345);
      end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_sticky", overrun6, 1'b1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun6, 1'b0);

    // Set and clear in the same cycle: set wins.
    seq = 20'hFFFFD;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    ovr_clr = 1'b1;
    tick();
    frame_start = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_setwins", overrun6, 1'b1);
    wait_valid(lat);
    chk("sw_seen", (lat != 0), 1'b1);
    chk("sw_bcd", bcd6, 24'h000003);
    chk("sw_neg", seq_neg6, 1'b1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("sw_clr", overrun6, 1'b0);

    // Reset in the middle of a conversion.
    seq = 20'h80000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_bcd", bcd6, 24'h0);
    chk("mrst_neg", seq_neg6, 1'b0);
    chk("mrst_busy", busy6, 1'b0);
    chk("mrst_bcd4", bcd4, 16'h0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bcd_valid6) pulses++;
    end
    chk("mrst_nopulse", pulses, 0);

    seq = 20'd99;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_valid(lat);
    chk("post_lat", lat, 21);
    chk("post_bcd", bcd6, 24'h000099);
    chk("post_neg", seq_neg6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
